// File: rtl/fp_iter_seq.sv
// fp_iter_seq: handshaked control sequencer for the iterative DSP48E1
// floating-point datapath (add, sub, mul).
// Walks PREALIGN/ALIGN/EXECUTE/NORMALIZE/ROUND and drives the DSP48E1
// control words plus the RAM and write-back strobes. All control outputs are
// registered and decoded from the next state, so they line up with the state
// they belong to.
// Optional feature macro: FPSEQ_ROUND_STAGE_EN. When it is defined, the ROUND
// state is present. When it is undefined, the result is truncated: write-back
// moves to the last NORMALIZE cycle and latency drops by one.
module fp_iter_seq #(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int SHIFT_STEP = 8,
    parameter int MUL_ITERS  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [1:0]                 operation,
    input  logic                       exc_in,
    input  logic [EXP_W:0]             align_shift,
    input  logic [$clog2(MAN_W+4)-1:0] lzc,
    output logic [3:0]                 alumode,
    output logic [6:0]                 opmode,
    output logic [4:0]                 inmode,
    output logic                       do_ram_read,
    output logic                       ram_sel,
    output logic                       fwd_dsp,
    output logic                       write_back,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic                       exc_flag,
    output logic                       busy
);

    localparam int unsigned STEP_U    = SHIFT_STEP;
    localparam int unsigned MAX_ALIGN = (MAN_W + 3 + SHIFT_STEP - 1) / SHIFT_STEP;
    localparam int          CNT_W     = $clog2(MAX_ALIGN + 1);
    localparam int          MUL_W     = $clog2(MUL_ITERS + 1);

    typedef enum logic [2:0] {
        IDLE, PREALIGN, ALIGN, EXECUTE, NORMALIZE, ROUND, EXCEPTION, DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_RSV = 2'b11
    } op_t;

    state_t             state, state_nxt;
    op_t                op_q, op_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [MUL_W-1:0]   mul_cnt, mul_cnt_nxt;

    // Number of shift cycles for a shift amount: at least one, at most MAX_ALIGN.
    function automatic logic [CNT_W-1:0] step_count(input int unsigned amount);
        int unsigned steps;
        steps = (amount + STEP_U - 1) / STEP_U;
        if (steps == 0)
            steps = 1;
        if (steps > MAX_ALIGN)
            steps = MAX_ALIGN;
        return CNT_W'(steps);
    endfunction

    assign op_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Next-state and counter update logic.
    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_nxt   = state;
        op_nxt      = op_q;
        cnt_nxt     = cnt;
        mul_cnt_nxt = mul_cnt;
        case (state)
            IDLE: begin
                if (op_valid) begin
                    state_nxt = PREALIGN;
                    op_nxt    = op_t'(operation);
                end
            end
            PREALIGN: begin
                if (exc_in || op_q == OP_RSV) begin
                    state_nxt = EXCEPTION;
                end else if (op_q == OP_MUL) begin
                    state_nxt   = EXECUTE;
                    mul_cnt_nxt = MUL_W'(MUL_ITERS);
                end else begin
                    state_nxt = ALIGN;
                    cnt_nxt   = step_count(32'(align_shift));
                end
            end
            ALIGN: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt   = EXECUTE;
                    mul_cnt_nxt = MUL_W'(1);   // add/sub execute in a single pass
                end
            end
            EXECUTE: begin
                if (mul_cnt == MUL_W'(1)) begin
                    state_nxt = NORMALIZE;
                    cnt_nxt   = step_count(32'(lzc));
                end else begin
                    mul_cnt_nxt = mul_cnt - MUL_W'(1);
                end
            end
            NORMALIZE: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
`ifdef FPSEQ_ROUND_STAGE_EN
                    state_nxt = ROUND;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef FPSEQ_ROUND_STAGE_EN
            ROUND:     state_nxt = DONE;
`endif
            EXCEPTION: state_nxt = DONE;
            DONE: begin
                if (res_ready)
                    state_nxt = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    // State, counters and control outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= OP_ADD;
            cnt         <= '0;
            mul_cnt     <= '0;
            alumode     <= '0;
            opmode      <= '0;
            inmode      <= '0;
            do_ram_read <= 1'b0;
            ram_sel     <= 1'b0;
            fwd_dsp     <= 1'b0;
            write_back  <= 1'b0;
            res_valid   <= 1'b0;
            exc_flag    <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; later assignments in the case override the defaults.
            state       <= state_nxt;
            op_q        <= op_nxt;
            cnt         <= cnt_nxt;
            mul_cnt     <= mul_cnt_nxt;
            alumode     <= '0;
            opmode      <= '0;
            inmode      <= '0;
            do_ram_read <= 1'b0;
            ram_sel     <= 1'b0;
            fwd_dsp     <= 1'b0;
            write_back  <= 1'b0;
            res_valid   <= 1'b0;
            exc_flag    <= 1'b0;
            case (state_nxt)
                PREALIGN: begin
                    do_ram_read <= 1'b1;
                    alumode     <= 4'b0011;
                    opmode      <= 7'b0110011;
                end
                ALIGN: begin
                    opmode  <= 7'b0000011;
                    fwd_dsp <= 1'b1;
                end
                EXECUTE: begin
                    if (op_nxt == OP_MUL) begin
                        opmode  <= 7'b0000101;
                        inmode  <= 5'b10001;
                        fwd_dsp <= (mul_cnt_nxt != MUL_W'(1));
                    end else begin
                        alumode <= (op_nxt == OP_SUB) ? 4'b0011 : 4'b0000;
                        opmode  <= 7'b0110011;
                    end
                end
                NORMALIZE: begin
                    opmode  <= 7'b0110000;
                    ram_sel <= 1'b1;
`ifndef FPSEQ_ROUND_STAGE_EN
                    write_back <= (cnt_nxt == CNT_W'(1));
`endif
                end
`ifdef FPSEQ_ROUND_STAGE_EN
                ROUND: begin
                    opmode     <= 7'b0110011;
                    write_back <= 1'b1;
                end
`endif
                EXCEPTION: begin
                    write_back <= 1'b1;
                    exc_flag   <= 1'b1;
                end
                DONE: begin
                    res_valid <= 1'b1;
                    exc_flag  <= exc_flag;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_iter_seq.sv
// Self-checking bench for fp_iter_seq: table-driven operations with a
// scoreboard queue, plus hand-written stall, ignore and mid-flight reset cases.
module tb_fp_iter_seq;

`ifdef FPSEQ_ROUND_STAGE_EN
    localparam int ROUND_CYC = 1;
`else
    localparam int ROUND_CYC = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic       op_ready;
    logic [1:0] operation;
    logic       exc_in;
    logic [8:0] align_shift;
    logic [4:0] lzc;
    logic [3:0] alumode;
    logic [6:0] opmode;
    logic [4:0] inmode;
    logic       do_ram_read;
    logic       ram_sel;
    logic       fwd_dsp;
    logic       write_back;
    logic       res_valid;
    logic       res_ready;
    logic       exc_flag;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    fp_iter_seq dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .operation(operation), .exc_in(exc_in), .align_shift(align_shift),
        .lzc(lzc), .alumode(alumode), .opmode(opmode), .inmode(inmode),
        .do_ram_read(do_ram_read), .ram_sel(ram_sel), .fwd_dsp(fwd_dsp),
        .write_back(write_back), .res_valid(res_valid), .res_ready(res_ready),
        .exc_flag(exc_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic       exc;
        logic [8:0] ash;
        logic [4:0] lz;
        int         a;     // expected ALIGN cycles
        int         e;     // expected EXECUTE cycles
        int         n;     // expected NORMALIZE cycles
        logic       x;     // expected exceptional result
    } vec_t;

    typedef struct {
        int         lat;
        int         wb_cyc;
        logic       exc;
        int         a;
        int         e;
        int         n;
        logic [3:0] exec_alu;
        logic [4:0] exec_in;
        int         fwd_exec;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", name, got, want);
    endtask

    function automatic exp_t make_exp(input vec_t v);
        exp_t r;
        r.exc      = v.x;
        r.a        = v.a;
        r.e        = v.e;
        r.n        = v.n;
        r.exec_alu = 4'b0000;
        r.exec_in  = 5'b00000;
        r.fwd_exec = 0;
        if (v.x) begin
            r.lat    = 3;
            r.wb_cyc = 2;
        end else begin
            r.lat    = 2 + v.a + v.e + v.n + ROUND_CYC;
            r.wb_cyc = r.lat - 1;
            if (v.op == 2'b01) r.exec_alu = 4'b0011;
            if (v.op == 2'b10) begin
                r.exec_in  = 5'b10001;
                r.fwd_exec = 1;
            end
        end
        return r;
    endfunction

    function automatic logic [21:0] pack_out();
        return {alumode, opmode, inmode, do_ram_read, ram_sel, fwd_dsp,
                write_back, res_valid, exc_flag};
    endfunction

    // Offer one operation at a negedge; returns after the accepting edge.
    task automatic start_op(input string tag, input logic [1:0] op, input logic exc,
                            input logic [8:0] ash, input logic [4:0] lz);
        @(negedge clk);
        check({tag, "_op_ready"}, op_ready, 1);
        operation   = op;
        exc_in      = exc;
        align_shift = ash;
        lzc         = lz;
        op_valid    = 1'b1;
        @(posedge clk);
    endtask

    // Observe the transaction cycle by cycle until res_valid, then score it.
    task automatic collect(input string tag);
        exp_t e;
        int k = 0;
        bit done = 0;
        int n_align = 0, n_exec = 0, n_norm = 0, n_wb = 0, n_fwd = 0;
        int wb_cyc = -1, lat = -1, pre_cyc = -1;
        logic [3:0] ex_alu = 4'b0000;
        logic [4:0] ex_in  = 5'b00000;
        logic x_seen = 1'b0;
        bit is_exec;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
            if (k == 1) op_valid = 1'b0;
            is_exec = (opmode == 7'b0110011 && !do_ram_read && !write_back) ||
                      (opmode == 7'b0000101);
            if (do_ram_read && alumode == 4'b0011 && opmode == 7'b0110011 && pre_cyc < 0)
                pre_cyc = k;
            if (opmode == 7'b0000011 && fwd_dsp) n_align++;
            if (is_exec) begin
                if (n_exec == 0) begin
                    ex_alu = alumode;
                    ex_in  = inmode;
                end
                n_exec++;
                if (fwd_dsp) n_fwd++;
            end
            if (opmode == 7'b0110000 && ram_sel) n_norm++;
            if (write_back) begin
                n_wb++;
                wb_cyc = k;
            end
            if (res_valid) begin
                done   = 1;
                lat    = k;
                x_seen = exc_flag;
            end
        end
        check({tag, "_res_valid_seen"}, 32'(done), 1);
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_latency"}, lat, e.lat);
            check({tag, "_prealign_cyc"}, pre_cyc, 1);
            check({tag, "_wb_count"}, n_wb, 1);
            check({tag, "_wb_cycle"}, wb_cyc, e.wb_cyc);
            check({tag, "_exc_flag"}, 32'(x_seen), 32'(e.exc));
            check({tag, "_align_cycles"}, n_align, e.a);
            check({tag, "_exec_cycles"}, n_exec, e.e);
            check({tag, "_norm_cycles"}, n_norm, e.n);
            check({tag, "_exec_alumode"}, 32'(ex_alu), 32'(e.exec_alu));
            check({tag, "_exec_inmode"}, 32'(ex_in), 32'(e.exec_in));
            check({tag, "_exec_fwd"}, n_fwd, e.fwd_exec);
        end
    endtask

    // Run a transaction with the consumer stalled, then release it.
    task automatic stall_case(input string tag, input vec_t v);
        logic [21:0] snap;
        res_ready = 1'b0;
        sb.push_back(make_exp(v));
        start_op(tag, v.op, v.exc, v.ash, v.lz);
        collect(tag);
        snap = pack_out();
        for (int i = 0; i < 5; i++) begin
            op_valid  = (i % 2 == 0);
            operation = 2'b10;
            @(negedge clk);
            check($sformatf("%s_hold%0d_outputs", tag, i), 32'(pack_out()), 32'(snap));
            check($sformatf("%s_hold%0d_op_ready", tag, i), 32'(op_ready), 0);
        end
        op_valid  = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check({tag, "_release_res_valid"}, 32'(res_valid), 0);
        check({tag, "_release_exc_flag"}, 32'(exc_flag), 0);
        check({tag, "_release_op_ready"}, 32'(op_ready), 1);
        @(negedge clk);
        check({tag, "_no_queued_op"}, 32'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t sv;
        int n_bad;

        //           op     exc   ash     lz     a  e  n  x
        vecs[0] = '{2'b00, 1'b0, 9'd0,   5'd0,  1, 1, 1, 1'b0};
        vecs[1] = '{2'b10, 1'b0, 9'd0,   5'd0,  0, 2, 1, 1'b0};
        vecs[2] = '{2'b01, 1'b0, 9'd20,  5'd3,  3, 1, 1, 1'b0};
        vecs[3] = '{2'b01, 1'b0, 9'd200, 5'd9,  4, 1, 2, 1'b0};
        vecs[4] = '{2'b00, 1'b1, 9'd5,   5'd5,  0, 0, 0, 1'b1};
        vecs[5] = '{2'b11, 1'b0, 9'd5,   5'd5,  0, 0, 0, 1'b1};
        vecs[6] = '{2'b00, 1'b0, 9'd8,   5'd31, 1, 1, 4, 1'b0};
        vecs[7] = '{2'b10, 1'b0, 9'd100, 5'd16, 0, 2, 2, 1'b0};
        vecs[8] = '{2'b00, 1'b0, 9'd9,   5'd8,  2, 1, 1, 1'b0};
        vecs[9] = '{2'b01, 1'b0, 9'd511, 5'd1,  4, 1, 1, 1'b0};

        rst = 1'b1; op_valid = 1'b0; operation = 2'b00; exc_in = 1'b0;
        align_shift = '0; lzc = '0; res_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'(pack_out()), 0);
        check("reset_op_ready", 32'(op_ready), 1);
        check("reset_busy", 32'(busy), 0);
        rst = 1'b0;

        // Table-driven operations, consumer always ready.
        for (int i = 0; i < 10; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            sb.push_back(make_exp(vecs[i]));
            start_op(tag, vecs[i].op, vecs[i].exc, vecs[i].ash, vecs[i].lz);
            collect(tag);
            @(negedge clk);
            check({tag, "_after_res_valid"}, 32'(res_valid), 0);
            check({tag, "_after_op_ready"}, 32'(op_ready), 1);
            exc_in = 1'b0;
        end

        // Consumer stall in DONE, normal and exceptional result.
        stall_case("stall_add", vecs[0]);
        sv = vecs[4];
        stall_case("stall_exc", sv);
        exc_in = 1'b0;

        // Reset while a mul is in EXECUTE.
        res_ready = 1'b1;
        start_op("rst_mul", 2'b10, 1'b0, 9'd0, 5'd0);
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        check("rst_mul_in_execute", 32'(inmode), 32'(5'b10001));
        rst = 1'b1;
        @(negedge clk);
        check("rst_mul_outputs", 32'(pack_out()), 0);
        check("rst_mul_op_ready", 32'(op_ready), 1);
        check("rst_mul_busy", 32'(busy), 0);
        rst = 1'b0;
        n_bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (write_back || res_valid || busy) n_bad++;
        end
        check("rst_mul_discarded", n_bad, 0);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_iter_seq.md
Name: fp_iter_seq

Overview:
- Parametrised, handshaked control sequencer for the iterative DSP48E1 floating-point unit. Supports add, sub and mul.
- Generalises the earlier fixed-format controller:
  - exponent/mantissa widths are parameters;
  - align and normalise loops are data-dependent;
  - there is a special-case/exception path;
  - input and output use valid/ready handshakes.
- Drives the DSP48E1 ALUMODE/OPMODE/INMODE words plus the operand-RAM and write-back strobes of the shared FP datapath.

Parameters:
- EXP_W, 8, exponent width
- MAN_W, 23, stored mantissa width (hidden bit excluded)
- SHIFT_STEP, 8, mantissa bits shifted per ALIGN or NORMALIZE cycle
- MUL_ITERS, 2, EXECUTE cycles for mul (partial-product passes)

Ports:
- clk, input, 1, clock; everything on rising edge
- rst, input, 1, reset; synchronous, active-high
- op_valid, input, 1, new operation offered
- op_ready, output, 1, sequencer can accept; equals (state==IDLE)
- operation, input, 2, 00 add, 01 sub, 10 mul, 11 reserved; sampled on accept
- exc_in, input, 1, datapath special-case detect (NaN/Inf/zero/denormal); valid in PREALIGN
- align_shift, input, EXP_W+1, exponent difference magnitude; valid in PREALIGN
- lzc, input, $clog2(MAN_W+4), leading-zero count; valid on last EXECUTE cycle
- alumode, output, 4, DSP48E1 ALUMODE
- opmode, output, 7, DSP48E1 OPMODE
- inmode, output, 5, DSP48E1 INMODE
- do_ram_read, output, 1, operand RAM read strobe
- ram_sel, output, 1, RAM port select (0 operands, 1 result)
- fwd_dsp, output, 1, forward P back to DSP input
- write_back, output, 1, result write strobe
- res_valid, output, 1, result available
- res_ready, input, 1, consumer accepts result
- exc_flag, output, 1, result is exceptional; valid with res_valid
- busy, output, 1, state != IDLE

Behaviour:
- Reset values: state=IDLE, all counters 0, alumode=0000, opmode=0000000, inmode=00000, all strobes 0, res_valid=0, exc_flag=0, op_ready=1, busy=0.
- Control outputs are registered and decoded from the next state, so they are aligned with the state they belong to.
- States: IDLE, PREALIGN, ALIGN, EXECUTE, NORMALIZE, ROUND, EXCEPTION, DONE.

Per-state behaviour:
- IDLE:
  - On op_valid&op_ready: latch operation, go to PREALIGN.
- PREALIGN (1 cycle):
  - do_ram_read=1, alumode=0011, opmode=0110011 (exponent subtract).
  - Transition:
    - exc_in or operation==11 -> EXCEPTION;
    - mul -> EXECUTE;
    - else -> ALIGN.
  - Load align counter = max(1, ceil(align_shift/SHIFT_STEP)), saturated at MAX_ALIGN = ceil((MAN_W+3)/SHIFT_STEP).
- ALIGN:
  - alumode=0000, opmode=0000011, fwd_dsp=1.
  - Decrement counter each cycle; -> EXECUTE when count==1.
- EXECUTE:
  - add: alumode=0000, opmode=0110011, inmode=00000, 1 cycle.
  - sub: alumode=0011, otherwise as add, 1 cycle.
  - mul: alumode=0000, opmode=0000101, inmode=10001, MUL_ITERS cycles, fwd_dsp=1 on all but the last.
  - On the last cycle, load the normalise counter = max(1, ceil(lzc/SHIFT_STEP)), saturated at MAX_ALIGN.
- NORMALIZE:
  - alumode=0000, opmode=0110000, ram_sel=1.
  - Count down as ALIGN; -> ROUND.
- ROUND (1 cycle):
  - alumode=0000, opmode=0110011 (add rounding constant).
  - write_back=1; -> DONE.
- EXCEPTION (1 cycle):
  - write_back=1, exc_flag set; -> DONE.
- DONE:
  - res_valid=1; hold all outputs stable until res_ready.
  - On res_ready: -> IDLE; res_valid and exc_flag clear the following cycle.

Cycle counts and boundary rules:
- Latency, accept edge to first res_valid: 1 + 1 + A + E + N + 1 cycles.
  - A = 0 for mul.
  - E = 1 (add/sub) or MUL_ITERS (mul).
- op_valid while busy: ignored, no queueing; op_ready=0.
- res_ready while not in DONE: ignored.
- align_shift=0 or lzc=0: still exactly 1 ALIGN or 1 NORMALIZE cycle.
- rst asserted in any state: IDLE on the next edge; the in-flight result is discarded and write_back is not issued.
- Counter width: $clog2(MAX_ALIGN+1); MUL_ITERS counter: $clog2(MUL_ITERS+1). MUL_ITERS must be >=1.

Optional Feature:
- Macro: FPSEQ_ROUND_STAGE_EN.
- Defined: ROUND state present as above.
- Undefined:
  - ROUND state removed; NORMALIZE last cycle -> DONE;
  - write_back=1 moves to the last NORMALIZE cycle;
  - latency is reduced by 1 (truncating result).

Test Plan:
1. Add with defaults, align_shift=0, lzc=0, res_ready=1, accept at cycle 0 -> states PREALIGN@1, ALIGN@2, EXECUTE@3, NORMALIZE@4, ROUND@5; res_valid=1 @6; op_ready=1 again @7.
2. Mul, MUL_ITERS=2 -> no ALIGN; EXECUTE @2-3 with inmode=10001, fwd_dsp=1 only @2; res_valid @6.
3. Sub, align_shift=20 -> 3 ALIGN cycles, alumode=0011 in EXECUTE. align_shift=200 -> ALIGN saturates at 4 cycles; res_valid @10.
4. exc_in=1 in PREALIGN (and separately operation=11) -> EXCEPTION @2, write_back=1 @2, res_valid=1 with exc_flag=1 @3.
5. res_ready held 0 for 5 cycles in DONE -> res_valid and all outputs stable; op_valid pulses ignored; IDLE one cycle after res_ready=1.
6. rst in EXECUTE during mul -> IDLE next edge, all outputs at reset values, no write_back. Rerun case 1 with FPSEQ_ROUND_STAGE_EN undefined -> res_valid @5, write_back @4.
